// File: rtl/hex_loader.sv
// -----------------------------------------------------------------------------
// hex_loader
//
// Purpose:
//   Parses a stream of ASCII characters from a file reader into bytes for the
//   RAM write stage. Each byte is written as two hex digits. Bytes are
//   separated by whitespace. A '#' starts a comment that runs to the end of
//   the line. A '.' terminates the load. Any malformed input or an overflow of
//   MAX_BYTES moves the block into a sticky error state.
//
// Parameters:
//   MAX_BYTES  - maximum number of bytes accepted per load (1..256).
//
// Ports:
//   clock      in   system clock; all logic runs on the rising edge.
//   reset      in   synchronous active-high reset.
//   char_in    in   [7:0] ASCII character from the file reader.
//   char_valid in   char_in is valid; one character is consumed per asserted cycle.
//   data_out   out  [7:0] assembled byte; holds its last value between pulses.
//   data_valid out  one-cycle pulse that marks data_out as valid.
//   byte_count out  [8:0] number of bytes emitted since reset.
//   done       out  terminator received (sticky until reset).
//   error      out  format or overflow error (sticky until reset).
// -----------------------------------------------------------------------------
module hex_loader #(
    parameter int MAX_BYTES = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [8:0] byte_count,
    output logic       done,
    output logic       error
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_HI      = 3'd0,
        S_LO      = 3'd1,
        S_SEP     = 3'd2,
        S_COMMENT = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_DIGIT   = 3'd0,
        C_SEP     = 3'd1,
        C_HASH    = 3'd2,
        C_DOT     = 3'd3,
        C_NEWLINE = 3'd4,   // a separator that also closes a comment
        C_ILLEGAL = 3'd5
    } char_class_t;

    localparam logic [8:0] MAX_CNT = 9'(MAX_BYTES);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t      state_q;
    logic [3:0]  hi_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic [8:0]  count_q;

    // -------------------------------------------------------------------------
    // Character classification (combinational)
    // -------------------------------------------------------------------------
    char_class_t cls;
    logic [3:0]  nibble;
    logic        is_num;
    logic        is_upper;
    logic        is_lower;

    always_comb begin
        is_num   = (char_in >= 8'h30) && (char_in <= 8'h39);   // '0'..'9'
        is_upper = (char_in >= 8'h41) && (char_in <= 8'h46);   // 'A'..'F'
        is_lower = (char_in >= 8'h61) && (char_in <= 8'h66);   // 'a'..'f'

        // The low nibble of '1'..'9' is the digit value itself. For letters
        // the low nibble of 'A'/'a' is 1, so adding 9 gives 10..15 for both cases.
        if (is_num) begin
            nibble = char_in[3:0];
        end else begin
            nibble = char_in[3:0] + 4'd9;
        end

        if (is_num || is_upper || is_lower) begin
            cls = C_DIGIT;
        end else begin
            case (char_in)
                8'h0A:                cls = C_NEWLINE;
                8'h20, 8'h09, 8'h0D:  cls = C_SEP;
                8'h23:                cls = C_HASH;
                8'h2E:                cls = C_DOT;
                default:              cls = C_ILLEGAL;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Byte assembly helpers
    // -------------------------------------------------------------------------
    logic [7:0] byte_d;
    logic [8:0] count_d;
    logic       at_limit;

    always_comb begin
        byte_d   = {hi_q, nibble};
        count_d  = count_q + 9'd1;
        at_limit = (count_q == MAX_CNT);
    end

    // -------------------------------------------------------------------------
    // Parser FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_HI;
            hi_q    <= 4'h0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            count_q <= 9'd0;
        end else begin
            // data_valid is a single-cycle pulse unless re-armed below.
            valid_q <= 1'b0;

            if (char_valid) begin
                case (state_q)
                    S_HI: begin
                        case (cls)
                            C_DIGIT: begin
                                hi_q    <= nibble;
                                state_q <= S_LO;
                            end
                            C_SEP, C_NEWLINE: state_q <= S_HI;
                            C_HASH:           state_q <= S_COMMENT;
                            C_DOT:            state_q <= S_DONE;
                            default:          state_q <= S_ERROR;
                        endcase
                    end

                    S_LO: begin
                        if (cls == C_DIGIT) begin
                            if (at_limit) begin
                                // Overflow: the byte is dropped and count stays put.
                                state_q <= S_ERROR;
                            end else begin
                                data_q  <= byte_d;
                                valid_q <= 1'b1;
                                count_q <= count_d;
                                state_q <= S_SEP;
                            end
                        end else begin
                            // Odd number of digits.
                            state_q <= S_ERROR;
                        end
                    end

                    S_SEP: begin
                        case (cls)
                            C_SEP, C_NEWLINE: state_q <= S_HI;
                            C_HASH:           state_q <= S_COMMENT;
                            C_DOT:            state_q <= S_DONE;
                            default:          state_q <= S_ERROR; // 3rd digit or illegal
                        endcase
                    end

                    S_COMMENT: begin
                        // Everything up to the line feed is ignored, including '.'.
                        if (cls == C_NEWLINE) begin
                            state_q <= S_HI;
                        end
                    end

                    S_DONE:  state_q <= S_DONE;
                    S_ERROR: state_q <= S_ERROR;

                    default: state_q <= S_ERROR;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign byte_count = count_q;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_hex_loader.sv
// -----------------------------------------------------------------------------
// tb_hex_loader
//
// Testbench for hex_loader. The stimulus process sends directed character
// streams and pushes the bytes it expects into a scoreboard queue. A monitor
// process pops a byte from the queue on every data_valid pulse and compares it.
// Status outputs are checked after each stream.
// -----------------------------------------------------------------------------
module tb_hex_loader;

    logic       clock;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic [7:0] data_out;
    logic       data_valid;
    logic [8:0] byte_count;
    logic       done;
    logic       error;

    int n_vec;
    int n_err;

    logic [7:0] sb[$];

    hex_loader #(.MAX_BYTES(256)) dut (
        .clock      (clock),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .byte_count (byte_count),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard monitor: sample away from the rising edge.
    always @(negedge clock) begin
        logic [7:0] exp_b;
        if (data_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: data_out=0x%02h, no byte expected", data_out);
            end else begin
                exp_b = sb.pop_front();
                if (data_out !== exp_b) begin
                    n_err++;
                    $display("FAIL byte: got 0x%02h expected 0x%02h", data_out, exp_b);
                end else begin
                    $display("byte 0x%02h ok", data_out);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clock);
        #1;
        char_valid = 1'b0;
    endtask

    // Sends characters back-to-back, one per cycle.
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            char_in    = s[i];
            char_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        char_valid = 1'b0;
    endtask

    // Holds a digit on char_in during reset so that it must be discarded.
    task automatic do_reset();
        reset      = 1'b1;
        char_in    = 8'h37;
        char_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset      = 1'b0;
        char_valid = 1'b0;
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        chk("rst_byte_count", int'(byte_count), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
    endtask

    task automatic settle_and_check(input string tag, input int cnt, input int dn,
                                    input int er);
        repeat (3) @(posedge clock);
        #1;
        chk({tag, "_byte_count"}, int'(byte_count), cnt);
        chk({tag, "_done"}, int'(done), dn);
        chk({tag, "_error"}, int'(error), er);
        chk({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        char_in    = 8'h00;
        char_valid = 1'b0;
        @(posedge clock);
        #1;

        // Two bytes, mixed case, then terminator.
        do_reset();
        sb.push_back(8'h3A);
        sb.push_back(8'h0F);
        send_str("3A 0f .");
        settle_and_check("s1", 2, 1, 0);
        chk("s1_data_hold", int'(data_out), 8'h0F);

        // Comment containing '.' is ignored.
        do_reset();
        sb.push_back(8'hFF);
        send_str("# x.y\nFF.");
        settle_and_check("s2", 1, 1, 0);

        // Odd digit count: error on the space, terminator ignored.
        do_reset();
        send_str("A ");
        #0;
        chk("s3_error_after_space", int'(error), 1);
        send_str(".");
        settle_and_check("s3", 0, 0, 1);
        chk("s3_data_out", int'(data_out), 0);

        // Three digits in a row.
        do_reset();
        sb.push_back(8'h12);
        send_str("12");
        chk("s4_error_before_3", int'(error), 0);
        send_str("3");
        settle_and_check("s4", 1, 0, 1);

        // Other separators, lowercase letters, and an ignored character after done.
        do_reset();
        sb.push_back(8'hA5);
        sb.push_back(8'hB7);
        sb.push_back(8'hC9);
        send_str("a5\tB7\r\nc9 .12");
        settle_and_check("s5", 3, 1, 0);

        // An illegal character moves the block to the error state.
        do_reset();
        send_str("g");
        settle_and_check("s6", 0, 0, 1);

        // Overflow: 257 bytes against MAX_BYTES=256.
        do_reset();
        for (int i = 0; i < 256; i++) sb.push_back(8'h00);
        for (int i = 0; i < 257; i++) send_str("00 ");
        settle_and_check("s7", 256, 0, 1);

        // Reset mid-byte discards the partial byte.
        do_reset();
        send_char(8'h34);
        do_reset();
        sb.push_back(8'h55);
        send_str("55.");
        settle_and_check("s8", 1, 1, 0);

        // Reset from the done state clears everything.
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hex_loader.md
HEX_LOADER -- requirements
Module: hex_loader

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 256, meaning the maximum number of bytes accepted per load (range 1..256).
REQ-002 The block SHALL have port clock  input  1  system clock, with all logic on the rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port char_in  input  8  ASCII character from the file reader.
REQ-005 The block SHALL have port char_valid  input  1  char_in is valid this cycle, one character consumed per asserted cycle.
REQ-006 The block SHALL have port data_out  output  8  assembled byte, feeding the RAM write stage data input.
REQ-007 The block SHALL have port data_valid  output  1  one-cycle pulse marking data_out valid, feeding the RAM write stage valid input.
REQ-008 The block SHALL have port byte_count  output  9  number of bytes emitted since reset.
REQ-009 The block SHALL have port done  output  1  terminator received; sticky.
REQ-010 The block SHALL have port error  output  1  format or overflow error; sticky.

Function
REQ-011 The block SHALL classify each character as:
- hex digit: '0'-'9', 'A'-'F', 'a'-'f', case-insensitive;
- separator: 0x20, 0x09, 0x0D, 0x0A;
- comment start: '#';
- terminator: '.';
- any other character: illegal.
REQ-012 The FSM SHALL have states S_HI, S_LO, S_SEP, S_COMMENT, S_DONE and S_ERROR, and SHALL advance only on cycles with char_valid=1.
REQ-013 In S_HI the FSM SHALL transition as follows:
- digit: latch it as the high nibble, go to S_LO;
- separator: stay in S_HI;
- '#': go to S_COMMENT;
- '.': go to S_DONE;
- illegal: go to S_ERROR.
REQ-014 In S_LO a digit SHALL complete the byte {hi, lo} and go to S_SEP; any other character, including a separator, SHALL go to S_ERROR (odd digit count).
REQ-015 In S_SEP the FSM SHALL transition as follows:
- separator: go to S_HI;
- '#': go to S_COMMENT;
- '.': go to S_DONE;
- digit: go to S_ERROR (more than two digits per byte);
- illegal: go to S_ERROR.
REQ-016 In S_COMMENT, 0x0A SHALL return the FSM to S_HI; all other characters, including '.', SHALL be ignored.
REQ-017 S_DONE and S_ERROR SHALL be absorbing states: characters are ignored and only reset exits them.
REQ-018 done SHALL equal 1 exactly when the FSM is in S_DONE, and error SHALL equal 1 exactly when it is in S_ERROR; the two SHALL never both be 1.
REQ-019 Byte emission latency SHALL be 1 cycle: data_out and data_valid register on the edge that samples the low digit, so data_valid is high for exactly the following cycle.
REQ-020 byte_count SHALL increment on the same edge as the data_valid assertion.
REQ-021 data_out SHALL hold its last value when data_valid=0.
REQ-022 If a byte completes while byte_count == MAX_BYTES, the block SHALL NOT pulse data_valid, SHALL leave byte_count unchanged, and SHALL enter S_ERROR.
REQ-023 byte_count SHALL never exceed MAX_BYTES and SHALL never wrap.
REQ-024 Back-to-back char_valid every cycle SHALL be supported with no dropped characters.
REQ-025 data_valid SHALL pulse at most once per 3 accepted characters.

Reset
REQ-026 While reset=1, the FSM SHALL go to S_HI and the outputs SHALL be: data_out=0x00, data_valid=0, byte_count=0, done=0, error=0; the hi-nibble register SHALL clear.
REQ-027 Reset SHALL take priority over char_valid in the same cycle; a character presented during reset SHALL be discarded.
REQ-028 Reset asserted mid-byte (in S_LO) or from S_DONE/S_ERROR SHALL abandon any partial byte and SHALL NOT pulse data_valid.

Verification
REQ-029 The bench SHALL cover stream "3A 0f ." -> data_valid pulses carrying 0x3A then 0x0F, byte_count=2, done=1, error=0.
REQ-030 The bench SHALL cover stream "# x.y\nFF." -> the comment is ignored, a single 0xFF is emitted, done=1, byte_count=1.
REQ-031 The bench SHALL cover stream "A ." -> no data_valid pulse, error=1 after the space, byte_count=0, and the following '.' is ignored (done=0).
REQ-032 The bench SHALL cover stream "123" -> 0x12 is emitted, error=1 on '3', byte_count=1.
REQ-033 The bench SHALL cover 257 bytes "00 " streamed back-to-back with MAX_BYTES=256 -> 256 pulses, byte_count=256, error=1, no 257th pulse.
REQ-034 The bench SHALL cover stream "4" then reset, then "55." -> no 0x4x byte, a single 0x55 is emitted, byte_count=1, done=1.
